// File: rtl/button_flag_bank.sv
// Debounced multi-channel push-button bank with press and long-press pulses.
// Long-press logic is present only when BTN_FLAG_LONG_PRESS_EN is defined.
module button_flag_bank #(
  parameter int CH          = 2,
  parameter int DB_CYCLES   = 4,
  parameter int LONG_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_sw,
  input  logic [CH-1:0] bt_in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] flag,
  output logic [CH-1:0] long_flag,
  output logic          any_flag
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [CH-1:0]  r_sync1;
  logic [CH-1:0]  r_sync2;
  logic [CH-1:0]  r_level;
  logic [CH-1:0]  r_flag;
  logic [DBW-1:0] r_db_cnt [CH];
  logic [CH-1:0]  w_toggle;

  // A channel flips when its mismatch count is about to reach DB_CYCLES
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < CH; i++) begin
      w_toggle[i] = (r_sync2[i] != r_level[i]) &&
                    (r_db_cnt[i] == DB_LAST);
    end
  end

  // Two-flop synchroniser for the raw asynchronous inputs
  always_ff @(posedge clk or negedge rst_sw) begin
    if (!rst_sw) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bt_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counters: count mismatch cycles, clear on match or accept
  always_ff @(posedge clk or negedge rst_sw) begin
    if (!rst_sw) begin
      for (int i = 0; i < CH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((r_sync2[i] == r_level[i]) || w_toggle[i])
          r_db_cnt[i] <= '0;
        else
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
      end
    end
  end

  // Accepted level and rising-edge press pulse, updated on the same edge
  always_ff @(posedge clk or negedge rst_sw) begin
    if (!rst_sw) begin
      r_level <= '0;
      r_flag  <= '0;
    end else begin
      r_level <= r_level ^ w_toggle;
      r_flag  <= w_toggle & ~r_level;
    end
  end

`ifdef BTN_FLAG_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] r_hold [CH];
  logic [CH-1:0] r_long;

  // Hold counters saturate, so the long pulse fires once per press
  always_ff @(posedge clk or negedge rst_sw) begin
    if (!rst_sw) begin
      for (int i = 0; i < CH; i++) r_hold[i] <= '0;
      r_long <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!r_level[i])
          r_hold[i] <= '0;
        else if (r_hold[i] != LONG_MAX)
          r_hold[i] <= r_hold[i] + LW'(1);
        r_long[i] <= r_level[i] && (r_hold[i] == LONG_LAST);
      end
    end
  end

  assign long_flag = r_long;
`else
  assign long_flag = '0;
`endif

  assign level    = r_level;
  assign flag     = r_flag;
  assign any_flag = |r_flag;

endmodule

// File: tb/tb_button_flag_bank.sv
// Directed scoreboard bench for button_flag_bank (CH=2, DB=4, LONG=16).
// Long-press expectations follow BTN_FLAG_LONG_PRESS_EN.
module tb_button_flag_bank;

`ifdef BTN_FLAG_LONG_PRESS_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] lv;
    logic [1:0] fl;
    logic [1:0] lf;
    logic       af;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_sw;
  logic [1:0] bt_in;
  logic [1:0] level;
  logic [1:0] flag;
  logic [1:0] long_flag;
  logic       any_flag;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  button_flag_bank #(
    .CH(2), .DB_CYCLES(4), .LONG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_sw(rst_sw),
    .bt_in(bt_in),
    .level(level),
    .flag(flag),
    .long_flag(long_flag),
    .any_flag(any_flag)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [1:0] el, input logic [1:0] ef,
                      input logic [1:0] elf);
    exp_t e;
    e.lv = el;
    e.fl = ef;
    e.lf = elf;
    e.af = |ef;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t got;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      got = {level, flag, long_flag, any_flag};
      assert (got === e) else begin
        n_err++;
        $error("FAIL %s: got lv=%b fl=%b lf=%b af=%b exp lv=%b fl=%b lf=%b af=%b",
               tag, level, flag, long_flag, any_flag,
               e.lv, e.fl, e.lf, e.af);
      end
    end
  endtask

  // drive bt_in, advance one edge, compare #1 later
  task automatic cyc(input logic [1:0] b, input logic [1:0] el,
                     input logic [1:0] ef, input logic [1:0] elf,
                     input string tag);
    bt_in = b;
    push(el, ef, elf);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_sw = 1'b0;
    bt_in  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    push(2'b00, 2'b00, 2'b00);
    check("reset");
    rst_sw = 1'b1;

    // single press held 30 cycles, then release
    for (int k = 1; k <= 30; k++)
      cyc(2'b01, {1'b0, k >= 6}, {1'b0, k == 6},
          {1'b0, LE && (k == 22)}, $sformatf("press0_e%0d", k));
    for (int k = 1; k <= 8; k++)
      cyc(2'b00, {1'b0, k < 6}, 2'b00, 2'b00,
          $sformatf("rel0_e%0d", k));

    // short glitches on channel 1
    for (int k = 1; k <= 3; k++)
      cyc(2'b10, 2'b00, 2'b00, 2'b00, "glitch3");
    for (int k = 1; k <= 2; k++)
      cyc(2'b00, 2'b00, 2'b00, 2'b00, "gap");
    for (int k = 1; k <= 2; k++)
      cyc(2'b10, 2'b00, 2'b00, 2'b00, "glitch2");
    for (int k = 1; k <= 6; k++)
      cyc(2'b00, 2'b00, 2'b00, 2'b00, "glitch_idle");

    // both channels together, short press
    for (int k = 1; k <= 10; k++)
      cyc(2'b11, {2{k >= 6}}, {2{k == 6}}, 2'b00,
          $sformatf("both_e%0d", k));
    for (int k = 1; k <= 10; k++)
      cyc(2'b00, {2{k < 6}}, 2'b00, 2'b00,
          $sformatf("both_rel_e%0d", k));

    // reset mid-press, then fresh debounce while still held
    for (int k = 1; k <= 8; k++)
      cyc(2'b01, {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00,
          $sformatf("pre_rst_e%0d", k));
    rst_sw = 1'b0;
    push(2'b00, 2'b00, 2'b00);
    #1;
    check("async_rst");
    for (int k = 1; k <= 3; k++)
      cyc(2'b01, 2'b00, 2'b00, 2'b00, "in_rst");
    rst_sw = 1'b1;
    for (int k = 1; k <= 40; k++)
      cyc(2'b01, {1'b0, k >= 6}, {1'b0, k == 6},
          {1'b0, LE && (k == 22)}, $sformatf("post_rst_e%0d", k));
    for (int k = 1; k <= 8; k++)
      cyc(2'b00, {1'b0, k < 6}, 2'b00, 2'b00,
          $sformatf("post_rel_e%0d", k));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
